// File: rtl/register_dump_serializer_pkg.sv
// Shared definitions for the register dump serializer: dump geometry,
// counter sizing and the FSM state encoding.
// Optional build macro: DUMP_CHECKSUM_EN (appends a checksum byte).
package register_dump_serializer_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_BYTE_WIDTH = 8;

  // Number of output beats needed to drain the whole flattened bus.
  function automatic int dump_bytes(input int data_width, input int num_regs,
                                    input int byte_width);
    return (num_regs * data_width) / byte_width;
  endfunction

  localparam int DUMP_BYTES = dump_bytes(DEF_DATA_WIDTH, DEF_NUM_REGS, DEF_BYTE_WIDTH);

  // One extra bit so the counter can also hold the full dump length.
  localparam int CNT_W = $clog2(DUMP_BYTES) + 1;

  // CHECK is only reachable when the checksum byte is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/register_dump_serializer.sv
// Register dump serializer: on a start pulse, snapshots the flattened
// register-file debug bus and streams it out one byte per valid/ready
// handshake, register 0 first, most significant byte first.
// Optional build macro: DUMP_CHECKSUM_EN -- when defined, a trailing byte
// equal to the two's-complement negation of the data byte sum is sent, so
// that all transmitted bytes sum to zero modulo 256.
module register_dump_serializer
  import register_dump_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] registers,
  output logic [BYTE_WIDTH-1:0]          txData,
  output logic                           txValid,
  input  logic                           txReady,
  output logic                           busy,
  output logic                           done
);

  localparam int TOTAL_W = DATA_WIDTH * NUM_REGS;
  localparam int NBYTES  = dump_bytes(DATA_WIDTH, NUM_REGS, BYTE_WIDTH);
  localparam int CW      = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  dump_state_t           state_reg;
  logic [TOTAL_W-1:0]    shadow_reg;
  logic [CW-1:0]         count_reg;

  logic [TOTAL_W-1:0]    shadow_next;
  logic [BYTE_WIDTH-1:0] byte_next;
  logic                  accept;
  logic                  last_beat;

  // Shifted snapshot and the byte that becomes visible after a handshake.
  assign shadow_next = shadow_reg << BYTE_WIDTH;
  assign byte_next   = shadow_next[TOTAL_W-1 -: BYTE_WIDTH];
  assign accept      = txValid && txReady;
  assign last_beat   = (count_reg == LAST_IDX);

`ifdef DUMP_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] sum_reg;
  logic [BYTE_WIDTH-1:0] sum_next;

  // Running sum including the byte being accepted this cycle.
  assign sum_next = sum_reg + txData;
`endif

  // Dump sequencer: snapshot on start, shift one byte per handshake,
  // optional checksum beat, then a single-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      count_reg  <= '0;
      txData     <= '0;
      txValid    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shadow_reg <= registers;
            count_reg  <= '0;
            txData     <= registers[TOTAL_W-1 -: BYTE_WIDTH];
            txValid    <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= SEND;
`ifdef DUMP_CHECKSUM_EN
            sum_reg    <= '0;
`endif
          end
        end

        SEND: begin
          // txData and txValid hold steady while the sink stalls.
          if (accept) begin
            shadow_reg <= shadow_next;
            count_reg  <= count_reg + 1'b1;
`ifdef DUMP_CHECKSUM_EN
            sum_reg    <= sum_next;
            if (last_beat) begin
              // Present the negated sum; the accumulator then stays frozen.
              txData    <= -sum_next;
              state_reg <= CHECK;
            end else begin
              txData    <= byte_next;
            end
`else
            txData <= byte_next;
            if (last_beat) begin
              txValid   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end
`endif
          end
        end

`ifdef DUMP_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            // Shadow is fully drained, so its top byte is zero again.
            txData    <= byte_next;
            txValid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
`endif

        DONE: begin
          // start is deliberately not sampled here.
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          txValid   <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_dump_serializer.sv
// Self-checking bench for register_dump_serializer. Expected bytes come
// from a register-array reference: byte k is lane (k mod 4) of register
// k/4, most significant lane first; with DUMP_CHECKSUM_EN an extra byte
// equal to the negated sum of the 128 data bytes follows.
module tb_register_dump_serializer;

  localparam int NB_DATA = 128;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB = NB_DATA + 1;
`else
  localparam int NB = NB_DATA;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1023:0] registers;
  logic [7:0]    txData;
  logic          txValid;
  logic          txReady;
  logic          busy;
  logic          done;

  logic [31:0]   regs [32];
  logic [31:0]   snap [32];

  int tests = 0;
  int fails = 0;
  int dump_no = 0;

  always #5 clk = ~clk;

  register_dump_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .registers (registers),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] pack_regs();
    logic [1023:0] bus;
    bus = '0;
    for (int i = 0; i < 32; i++) bus[1023 - 32*i -: 32] = regs[i];
    return bus;
  endfunction

  function automatic logic [7:0] data_byte(input int k);
    return 8'(snap[k / 4] >> (8 * (3 - (k % 4))));
  endfunction

  function automatic logic [7:0] exp_byte(input int k);
    int s;
    if (k < NB_DATA) return data_byte(k);
    s = 0;
    for (int j = 0; j < NB_DATA; j++) s += int'(data_byte(j));
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // Pulse start at a negedge; the capture edge follows. Optionally clobber
  // the live bus right after capture to prove the snapshot is used.
  task automatic kick(input bit clobber);
    for (int i = 0; i < 32; i++) snap[i] = regs[i];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("valid_after_start", {31'd0, txValid}, 32'd1);
    if (clobber) registers = '1;
  endtask

  // Drive txReady per mode (0: always, 1: toggling, 2: random), check each
  // presented byte against the reference and the done timing.
  task automatic drain(input int mode, input int inject_at, input int abort_at,
                       output int got);
    int  cyc;
    bit  injected;
    bit  final_acc;
    bit  finished;
    cyc = 0; injected = 0; final_acc = 0; finished = 0; got = 0;
    while (cyc < 3000) begin
      if (got == abort_at) begin
        finished = 1;
        break;
      end
      if (final_acc) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("valid_at_done", {31'd0, txValid}, 32'd0);
        if (mode == 0) chk("latency", cyc, NB);
        finished = 1;
        break;
      end
      chk("done_early", {31'd0, done}, 32'd0);
      chk("busy_in_dump", {31'd0, busy}, 32'd1);
      chk("valid_in_dump", {31'd0, txValid}, 32'd1);
      chk($sformatf("byte%0d", got), {24'd0, txData}, {24'd0, exp_byte(got)});
      case (mode)
        0:       txReady = 1'b1;
        1:       txReady = cyc[0];
        default: txReady = 1'($urandom_range(0, 1));
      endcase
      start = 1'b0;
      if (!injected && got == inject_at) begin
        start = 1'b1;
        injected = 1;
      end
      if (txValid && txReady) begin
        got++;
        if (got == NB) final_acc = 1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("drain_bounded", {31'd0, finished}, 32'd1);
    dump_no++;
    $display("[TB] dump %0d mode %0d: %0d bytes accepted in %0d cycles", dump_no, mode, got, cyc);
  endtask

  // In the DONE cycle: pulse start (must be ignored) and confirm idle.
  task automatic post_done();
    start = 1'b1;
    txReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("idle_valid", {31'd0, txValid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("no_queued_start", {31'd0, txValid | busy}, 32'd0);
  endtask

  initial begin
    int got;
    reset = 1'b1;
    start = 1'b0;
    txReady = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}};
    registers = pack_regs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, txValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {24'd0, txData}, 32'd0);
    reset = 1'b0;

    // Ready while idle must not produce anything.
    txReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_ready_valid", {31'd0, txValid}, 32'd0);

    // Full-rate dump of {i,i,i,i}.
    kick(0); drain(0, -1, -1, got); post_done();
    // Toggling backpressure.
    kick(0); drain(1, -1, -1, got); post_done();
    // Bus overwritten after capture.
    kick(1); drain(0, -1, -1, got); post_done();
    registers = pack_regs();
    // start re-pulsed at byte 10 and in the DONE cycle.
    kick(0); drain(1, 10, -1, got); post_done();

    // Reset after byte 40 is accepted.
    kick(0); drain(0, -1, 41, got);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", {31'd0, txValid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {24'd0, txData}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    kick(0); drain(0, -1, -1, got); post_done();

    // Random register contents with random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      registers = pack_regs();
      kick(0); drain(2, -1, -1, got); post_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
